// File: rtl/vr_wiper_ctrl_pkg.sv
// Shared definitions for the vr wiper sequencer and the vr stepper.
//   - pot address codes (R/G/B gain, then R/G/B ref)
//   - step direction codes
//   - sequencer FSM state encoding
//   - round-robin channel advance helper
package vr_wiper_ctrl_pkg;

   localparam int unsigned ADDR_W = 3;

   localparam logic [ADDR_W-1:0] CH_R_GAIN = 3'd0;
   localparam logic [ADDR_W-1:0] CH_G_GAIN = 3'd1;
   localparam logic [ADDR_W-1:0] CH_B_GAIN = 3'd2;
   localparam logic [ADDR_W-1:0] CH_R_REF  = 3'd3;
   localparam logic [ADDR_W-1:0] CH_G_REF  = 3'd4;
   localparam logic [ADDR_W-1:0] CH_B_REF  = 3'd5;

   localparam logic UD_UP = 1'b1;
   localparam logic UD_DN = 1'b0;

   // One step handshake is shared by calibration and tracking; cal_done
   // tells the two phases apart.
   typedef enum logic [2:0] {
      StIssue,
      StWaitLo,
      StWaitHi,
      StGap,
      StScan
   } state_e;

   function automatic logic [ADDR_W-1:0] next_ch(input logic [ADDR_W-1:0] ch,
                                                 input logic [ADDR_W-1:0] last);
      return (ch == last) ? '0 : ch + 1'b1;
   endfunction

endpackage

// File: rtl/vr_wiper_ctrl_if.sv
// Step-request link between the wiper sequencer and the vr stepper.
//   vr_start : one-cycle step request (sequencer -> vr)
//   vr_ud    : step direction, 1 = up (sequencer -> vr)
//   vr_addr  : pot select, stable for the whole step (sequencer -> vr)
//   vr_ready : vr idle indication, registered (vr -> sequencer)
interface vr_wiper_ctrl_if;
   import vr_wiper_ctrl_pkg::*;

   logic              vr_start;
   logic              vr_ud;
   logic [ADDR_W-1:0] vr_addr;
   logic              vr_ready;

   modport master (
      output vr_start,
      output vr_ud,
      output vr_addr,
      input  vr_ready
   );

   modport slave (
      input  vr_start,
      input  vr_ud,
      input  vr_addr,
      output vr_ready
   );

endinterface

// File: rtl/vr_wiper_ctrl.sv
// Wiper sequencer for the vr digital-potentiometer stepper.
// Holds a target tap per pot and the believed wiper position, and issues
// single-step requests to vr until every wiper matches its target. After
// reset every wiper is driven fully down so positions are known without
// readback.
// Ports:
//   clk, reset         : system clock, synchronous active-high reset
//   wr_en/addr/data    : one-cycle target write; addr >= NUM_CH is ignored
//   vr (master)        : step request link to vr
//   cal_done           : calibration of all channels finished
//   busy               : calibrating, stepping, or any position off target
//   settled[i]         : cal_done and pos[i] == target[i]
module vr_wiper_ctrl
   import vr_wiper_ctrl_pkg::*;
#(
   parameter int unsigned TAPS_W   = 5,
   parameter int unsigned NUM_CH   = 6,
   parameter int unsigned STEP_GAP = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [TAPS_W-1:0] wr_data,
   vr_wiper_ctrl_if.master   vr,
   output logic              cal_done,
   output logic              busy,
   output logic [NUM_CH-1:0] settled
);

   localparam logic [ADDR_W:0]   NumChW  = (ADDR_W + 1)'(NUM_CH);
   localparam logic [ADDR_W-1:0] LastCh  = ADDR_W'(NUM_CH - 1);
   localparam logic [TAPS_W:0]   CalLast = (TAPS_W + 1)'(2 ** TAPS_W - 1);
   localparam int unsigned       GapW    = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
   localparam logic [GapW-1:0]   GapLast = GapW'((STEP_GAP > 0) ? STEP_GAP - 1 : 0);

   state_e              state_q, state_d;
   logic [TAPS_W-1:0]   target_q [NUM_CH];
   logic [TAPS_W-1:0]   target_d [NUM_CH];
   logic [TAPS_W-1:0]   pos_q    [NUM_CH];
   logic [TAPS_W-1:0]   pos_d    [NUM_CH];
   logic [ADDR_W-1:0]   scan_ptr_q, scan_ptr_d;
   logic [TAPS_W:0]     cal_cnt_q, cal_cnt_d;
   logic [GapW-1:0]     gap_cnt_q, gap_cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                ud_q, ud_d;
   logic                cal_done_q, cal_done_d;
   logic                start;
   logic [NUM_CH-1:0]   match;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIssue;
         target_q   <= '{default: '0};
         pos_q      <= '{default: '0};
         scan_ptr_q <= '0;
         cal_cnt_q  <= '0;
         gap_cnt_q  <= '0;
         addr_q     <= '0;
         ud_q       <= UD_DN;
         cal_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         target_q   <= target_d;
         pos_q      <= pos_d;
         scan_ptr_q <= scan_ptr_d;
         cal_cnt_q  <= cal_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         addr_q     <= addr_d;
         ud_q       <= ud_d;
         cal_done_q <= cal_done_d;
      end
   end

   always_comb begin
      state_e after_step;

      state_d    = state_q;
      target_d   = target_q;
      pos_d      = pos_q;
      scan_ptr_d = scan_ptr_q;
      cal_cnt_d  = cal_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      addr_d     = addr_q;
      ud_d       = ud_q;
      cal_done_d = cal_done_q;
      start      = 1'b0;
      after_step = StScan;

      // Writes land in any state; a step in flight is not aborted.
      if (wr_en && ({1'b0, wr_addr} < NumChW)) begin
         target_d[wr_addr] = wr_data;
      end

      case (state_q)
         StScan: begin
            if (pos_q[scan_ptr_q] != target_q[scan_ptr_q]) begin
               addr_d  = scan_ptr_q;
               ud_d    = (target_q[scan_ptr_q] > pos_q[scan_ptr_q]) ? UD_UP : UD_DN;
               state_d = StIssue;
            end else begin
               scan_ptr_d = next_ch(scan_ptr_q, LastCh);
            end
         end

         StIssue: begin
            if (vr.vr_ready) begin
               start   = 1'b1;
               state_d = StWaitLo;
            end
         end

         StWaitLo: begin
            if (!vr.vr_ready) begin
               state_d = StWaitHi;
            end
         end

         StWaitHi: begin
            if (vr.vr_ready) begin
               if (!cal_done_q) begin
                  after_step = StIssue;
                  if (cal_cnt_q == CalLast) begin
                     cal_cnt_d = '0;
                     if (addr_q == LastCh) begin
                        cal_done_d = 1'b1;
                        pos_d      = '{default: '0};
                        after_step = StScan;
                     end else begin
                        addr_d = addr_q + 1'b1;
                     end
                  end else begin
                     cal_cnt_d = cal_cnt_q + 1'b1;
                  end
               end else begin
                  // Saturate so a stale direction can never wrap the position.
                  if (ud_q == UD_UP) begin
                     if (pos_q[addr_q] != '1) pos_d[addr_q] = pos_q[addr_q] + 1'b1;
                  end else begin
                     if (pos_q[addr_q] != '0) pos_d[addr_q] = pos_q[addr_q] - 1'b1;
                  end
                  scan_ptr_d = next_ch(scan_ptr_q, LastCh);
               end

               if (STEP_GAP == 0) begin
                  state_d = after_step;
               end else begin
                  gap_cnt_d = '0;
                  state_d   = StGap;
               end
            end
         end

         StGap: begin
            if (gap_cnt_q == GapLast) begin
               state_d = cal_done_q ? StScan : StIssue;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end

         default: state_d = StIssue;
      endcase
   end

   always_comb begin
      match = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         match[i] = (pos_q[i] == target_q[i]);
      end
   end

   assign vr.vr_start = start;
   assign vr.vr_ud    = ud_q;
   assign vr.vr_addr  = addr_q;
   assign cal_done    = cal_done_q;
   assign settled     = cal_done_q ? match : '0;
   assign busy        = !cal_done_q || (state_q != StScan) || !(&match);

endmodule
